// File: rtl/da_ctrl.sv
// da_ctrl: sequencer for the distributed-arithmetic FIR datapath.
//
// Loads coefficients from the host config stream into the datapath ROMs. Once
// a full set is loaded, it accepts samples and runs the bit-serial accumulate
// sequence, pulsing done when each result is valid.
//
// Optional feature: define DA_CTRL_AUTOADDR_EN to generate the ROM write
// address internally. In that mode cfg_addr and cfg_last are ignored, and a load
// completes after NUM_ROMS*ROM_DEPTH writes.
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   cfg_valid/cfg_ready          host coefficient write handshake
//   cfg_addr, cfg_data, cfg_last write address {rom, entry}, data, end of burst
//   CADDR, CIN, CLOAD            ROM write port to the datapath
//   samp_valid/samp_ready        sample handshake (sample data bypasses this block)
//   samp_load                    datapath latches the sample vector
//   acc_clr, acc_en, acc_sub     accumulator clear / shift-accumulate / subtract
//   bit_sel                      sample bit index driving the ROM addresses, LSB first
//   coef_ok                      a complete coefficient set is loaded
//   done                         one-cycle pulse, accumulator result valid
module da_ctrl #(
    parameter int unsigned NUM_ROMS  = 8,
    parameter int unsigned ROM_DEPTH = 256,
    parameter int unsigned COEF_W    = 20,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AW        = 11,
    parameter int unsigned BW        = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic [AW-1:0]     CADDR,
    output logic [COEF_W-1:0] CIN,
    output logic              CLOAD,
    input  logic              samp_valid,
    output logic              samp_ready,
    output logic              samp_load,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              acc_sub,
    output logic [BW-1:0]     bit_sel,
    output logic              coef_ok,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOAD, READY, COMPUTE, DONE} state_t;

    state_t          state;
    logic            samp_rdy_q;
    logic            cfg_acc;
    logic            samp_acc;
    logic            wr_last;
    logic [AW-1:0]   wr_addr;

    // A config write in READY wins over a sample offered in the same cycle.
    assign samp_ready = samp_rdy_q & ~cfg_valid;
    assign cfg_acc    = cfg_valid & cfg_ready;
    assign samp_acc   = samp_valid & samp_ready;

`ifdef DA_CTRL_AUTOADDR_EN
    localparam int unsigned NUM_WORDS = NUM_ROMS * ROM_DEPTH;

    logic [AW-1:0] addr_cnt;
    logic          unused_cfg;

    assign unused_cfg = ^{cfg_addr, cfg_last};

    // A load always starts at address 0, whether it begins from IDLE or READY.
    assign wr_addr = (state == LOAD) ? addr_cnt : '0;
    assign wr_last = (wr_addr == AW'(NUM_WORDS - 1));

    // Write-address counter: the next address after each accepted write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_cnt <= '0;
        end else if (cfg_acc) begin
            addr_cnt <= wr_addr + AW'(1);
        end
    end
`else
    logic unused_params;

    assign unused_params = ^{32'(NUM_ROMS), 32'(ROM_DEPTH)};
    assign wr_addr       = cfg_addr;
    assign wr_last       = cfg_last;
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cfg_ready  <= 1'b0;
            samp_rdy_q <= 1'b0;
            CADDR      <= '0;
            CIN        <= '0;
            CLOAD      <= 1'b0;
            samp_load  <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            acc_sub    <= 1'b0;
            bit_sel    <= '0;
            coef_ok    <= 1'b0;
            done       <= 1'b0;
        end else begin
            CLOAD     <= 1'b0;
            samp_load <= 1'b0;
            acc_clr   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE, LOAD, READY: begin
                    cfg_ready <= 1'b1;
                    if (cfg_acc) begin
                        CLOAD <= 1'b1;
                        CADDR <= wr_addr;
                        CIN   <= cfg_data;
                        if (wr_last) begin
                            state      <= READY;
                            coef_ok    <= 1'b1;
                            samp_rdy_q <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            coef_ok    <= 1'b0;
                            samp_rdy_q <= 1'b0;
                        end
                    end else if ((state == READY) && samp_acc) begin
                        state      <= COMPUTE;
                        cfg_ready  <= 1'b0;
                        samp_rdy_q <= 1'b0;
                        samp_load  <= 1'b1;
                        acc_clr    <= 1'b1;
                        acc_en     <= 1'b1;
                        bit_sel    <= '0;
                        acc_sub    <= (DATA_W == 1);
                    end
                end
                COMPUTE: begin
                    if (bit_sel == BW'(DATA_W - 1)) begin
                        state   <= DONE;
                        acc_en  <= 1'b0;
                        acc_sub <= 1'b0;
                        bit_sel <= '0;
                        done    <= 1'b1;
                    end else begin
                        bit_sel <= bit_sel + BW'(1);
                        // The MSB is the two's-complement sign bit and is subtracted.
                        acc_sub <= (bit_sel == BW'(DATA_W - 2));
                    end
                end
                DONE: begin
                    state      <= READY;
                    cfg_ready  <= 1'b1;
                    samp_rdy_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_ctrl.sv
// Scoreboard bench for da_ctrl: the stimulus pushes the expected output events;
// the monitor pops an event and compares it on every cycle with activity.
module tb_da_ctrl;

    localparam int unsigned AW        = 11;
    localparam int unsigned COEF_W    = 20;
    localparam int unsigned BW        = 3;
    localparam int unsigned NUM_WORDS = 2048;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [AW-1:0]     cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_last;
    logic [AW-1:0]     CADDR;
    logic [COEF_W-1:0] CIN;
    logic              CLOAD;
    logic              samp_valid;
    logic              samp_ready;
    logic              samp_load;
    logic              acc_clr;
    logic              acc_en;
    logic              acc_sub;
    logic [BW-1:0]     bit_sel;
    logic              coef_ok;
    logic              done;

    da_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .CADDR      (CADDR),
        .CIN        (CIN),
        .CLOAD      (CLOAD),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .samp_load  (samp_load),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .acc_sub    (acc_sub),
        .bit_sel    (bit_sel),
        .coef_ok    (coef_ok),
        .done       (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic        cload;
        logic [10:0] caddr;
        logic [19:0] cin;
        logic        sl;
        logic        clr;
        logic        en;
        logic        sub;
        logic [2:0]  bs;
        logic        dn;
    } ev_t;

    ev_t exp_q[$];

    logic [10:0] last_a;
    logic [19:0] last_d;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle with write or compute activity must match the queue head.
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        a = '0;
        a.cyc   = cyc;
        a.cload = CLOAD;
        if (CLOAD) begin
            a.caddr = CADDR;
            a.cin   = CIN;
        end
        a.sl  = samp_load;
        a.clr = acc_clr;
        a.en  = acc_en;
        a.sub = acc_sub;
        if (acc_en) a.bs = bit_sel;
        a.dn = done;
        if (CLOAD || samp_load || acc_clr || acc_en || done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 96'(a), 96'(0));
            end else begin
                e = exp_q.pop_front();
                chk("event", 96'(a), 96'(e));
            end
        end
    end

    // Expected compute sequence for a sample accepted at cycle t (first n events).
    task automatic push_compute(input int unsigned t, input int n);
        ev_t e;
        for (int k = 1; k <= n; k++) begin
            e = '0;
            e.cyc = t + k;
            if (k <= 8) begin
                e.en  = 1'b1;
                e.bs  = 3'(k - 1);
                e.sub = (k == 8);
                e.sl  = (k == 1);
                e.clr = (k == 1);
            end else begin
                e.dn = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic cfg_wr(input logic [10:0] addr, input logic [19:0] data,
                          input logic last, input logic [10:0] exp_addr);
        ev_t e;
        bit  got;
        got       = 1'b0;
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_last  = last;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) begin
                got     = 1'b1;
                e       = '0;
                e.cyc   = cyc + 1;
                e.cload = 1'b1;
                e.caddr = exp_addr;
                e.cin   = data;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        last_a    = exp_addr;
        last_d    = data;
        if (!got) chk("cfg_wr_timeout", 96'(0), 96'(1));
    endtask

    task automatic samp_take(output int unsigned t, input int nev);
        bit got;
        got        = 1'b0;
        t          = 0;
        samp_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (samp_ready === 1'b1) begin
                got = 1'b1;
                t   = cyc;
                push_compute(t, nev);
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("samp_timeout", 96'(0), 96'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", 96'(exp_q.size()), 96'(0));
    endtask

`ifdef DA_CTRL_AUTOADDR_EN
    task automatic load_all(input int start);
        for (int i = start; i < int'(NUM_WORDS); i++) begin
            cfg_wr(11'h7FF, 20'(i * 7 + 3), 1'b0, 11'(i));
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned ts [3];
        resetn     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_last   = 1'b0;
        samp_valid = 1'b0;
        last_a     = '0;
        last_d     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 96'({CADDR, CIN, CLOAD, samp_load, acc_clr, acc_en, acc_sub,
                               bit_sel, coef_ok, done, samp_ready, cfg_ready}), 96'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("cfg_ready_pre", 96'(cfg_ready), 96'(0));
        @(negedge clk);
        chk("cfg_ready_post", 96'(cfg_ready), 96'(1));
        @(posedge clk);
        #1;

        // Coefficient load
`ifdef DA_CTRL_AUTOADDR_EN
        load_all(0);
`else
        cfg_wr(11'd0, 20'd0, 1'b0, 11'd0);
        cfg_wr(11'd1, 20'd1, 1'b0, 11'd1);
        @(posedge clk);
        #1;
        cfg_wr(11'd256, 20'd256, 1'b0, 11'd256);
        @(negedge clk);
        chk("coef_ok_mid_load", 96'(coef_ok), 96'(0));
        @(posedge clk);
        #1;
        cfg_wr(11'd2047, 20'd2047, 1'b1, 11'd2047);
`endif
        @(negedge clk);
        chk("coef_ok_loaded", 96'(coef_ok), 96'(1));
        chk("samp_ready_loaded", 96'(samp_ready), 96'(1));
        @(negedge clk);
        chk("caddr_cin_hold", 96'({CADDR, CIN}), 96'({last_a, last_d}));
        @(posedge clk);
        #1;

        // Single sample timing
        samp_take(t, 9);
        samp_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("samp_ready_compute", 96'({samp_ready, cfg_ready}), 96'(0));
        repeat (4) @(negedge clk);
        chk("samp_ready_done", 96'(samp_ready), 96'(0));
        @(negedge clk);
        chk("samp_ready_back", 96'(samp_ready), 96'(1));
        @(posedge clk);
        #1;

        // Back-to-back samples with samp_valid held
        for (int i = 0; i < 3; i++) begin
            samp_take(ts[i], 9);
            if (i > 0) chk("sample_spacing", 96'(ts[i] - ts[i-1]), 96'(10));
        end
        samp_valid = 1'b0;
        wait_drain();
        @(posedge clk);
        #1;

        // Config write and sample offered together in READY
        begin
            ev_t e;
            samp_valid = 1'b1;
            cfg_valid  = 1'b1;
            cfg_addr   = 11'd5;
            cfg_data   = 20'hABCDE;
            cfg_last   = 1'b0;
            @(negedge clk);
            chk("conflict_samp_ready", 96'(samp_ready), 96'(0));
            chk("conflict_cfg_ready", 96'(cfg_ready), 96'(1));
            e       = '0;
            e.cyc   = cyc + 1;
            e.cload = 1'b1;
`ifdef DA_CTRL_AUTOADDR_EN
            e.caddr = 11'd0;
`else
            e.caddr = 11'd5;
`endif
            e.cin   = 20'hABCDE;
            exp_q.push_back(e);
            @(posedge clk);
            #1 cfg_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("conflict_in_load", 96'({coef_ok, samp_ready}), 96'(0));
            end
            @(posedge clk);
            #1 samp_valid = 1'b0;
        end
`ifdef DA_CTRL_AUTOADDR_EN
        load_all(1);
`else
        cfg_wr(11'd6, 20'h12345, 1'b1, 11'd6);
`endif
        @(negedge clk);
        chk("coef_ok_reload", 96'(coef_ok), 96'(1));
        @(posedge clk);
        #1;

        // Reset during compute at T+4
        samp_take(t, 3);
        samp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("abort_outs", 96'({CADDR, CIN, CLOAD, samp_load, acc_clr, acc_en, acc_sub,
                               bit_sel, coef_ok, done, samp_ready, cfg_ready}), 96'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        samp_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("after_abort", 96'({coef_ok, samp_ready}), 96'(0));
        end
        @(posedge clk);
        #1 samp_valid = 1'b0;
`ifdef DA_CTRL_AUTOADDR_EN
        load_all(0);
`else
        cfg_wr(11'd7, 20'h55555, 1'b1, 11'd7);
`endif
        @(negedge clk);
        chk("coef_ok_after_abort", 96'({coef_ok, samp_ready}), 96'(3));
        @(posedge clk);
        #1;
        samp_take(t, 9);
        samp_valid = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
